isr_ctl: RTL and testbench

In-service register and interrupt-acknowledge controller for the 8259A-compatible PIC. Sits directly downstream of the priority resolver: it consumes the resolver's `intr`/`code`, runs the two-pulse INTA handshake, owns the ISR bits and the rotating lowest-priority pointer `sp`, and feeds `isr` and `sp` back to the resolver. It also executes OCW2 EOI/rotation commands and drives the interrupt vector onto the data bus.

---
 rtl/pic_pkg.sv | 27 ++
 rtl/isr_prio_find.sv | 30 +++
 rtl/isr_ctl.sv | 176 +++++++++++++++++
 tb/tb_isr_ctl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259A-compatible PIC blocks.
//   isr_state_e  : INTA handshake state of isr_ctl
//   OCW_*        : OCW2 R/SL/EOI command codes
//   LVL_SPURIOUS : level reported when INTA arrives with no request pending
//   lvl_onehot() : 3-bit level to 8-bit one-hot mask
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } isr_state_e;

  localparam logic [2:0] OCW_NS_EOI  = 3'b001;
  localparam logic [2:0] OCW_SP_EOI  = 3'b011;
  localparam logic [2:0] OCW_ROT_NS  = 3'b101;
  localparam logic [2:0] OCW_ROT_SP  = 3'b111;
  localparam logic [2:0] OCW_SET_PRI = 3'b110;

  localparam logic [2:0] LVL_SPURIOUS = 3'd7;

  function automatic logic [7:0] lvl_onehot(input logic [2:0] lvl);
    return 8'b0000_0001 << lvl;
  endfunction

endpackage

// File: rtl/isr_prio_find.sv
// isr_prio_find: combinational rotating priority encoder.
// Level sp is the lowest priority, so the search order is sp+1, sp+2, ... sp
// (modulo 8).
//   bits [7:0] : candidate bits
//   sp   [2:0] : lowest-priority level
//   hit        : any bit set
//   idx  [2:0] : highest-priority set level (0 when hit=0)
module isr_prio_find
  import pic_pkg::*;
(
  input  logic [7:0] bits,
  input  logic [2:0] sp,
  output logic       hit,
  output logic [2:0] idx
);

  logic [2:0] cand;

  // Walk from lowest to highest priority; the last hit written wins.
  always_comb begin
    hit  = |bits;
    idx  = '0;
    cand = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = sp + 3'(i + 1);
      if (bits[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/isr_ctl.sv
// isr_ctl: in-service register and INTA handshake controller of the PIC.
// Runs the two-pulse INTA sequence, owns the ISR and the rotating
// lowest-priority pointer sp, executes OCW2 EOI/rotation commands and
// drives the vector byte. All outputs are registered.
//   clk, rst_n       : clock, synchronous active-low reset
//   intr_in, code_in : request / highest pending level from the resolver
//   inta_n           : CPU acknowledge (active low, synchronous to clk)
//   ocw_wr, ocw_cmd, ocw_level : OCW2 write strobe, R/SL/EOI, L2..L0
//   vec_base         : ICW2 T7..T3
//   isr, sp          : in-service bits and lowest-priority level
//   int_out          : INT to the CPU
//   vec_out, vec_oe  : vector byte and data-bus drive enable
//   irr_clr          : one-cycle one-hot clear of the acknowledged IRR bit
// Build option ISR_AEOI_EN: adds input aeoi; when set, the end of the second
// INTA pulse clears the acknowledged ISR bit.
//
// state | meaning
// IDLE  | waiting for the first INTA fall
// ACK1  | first INTA pulse low, level latched
// GAP   | between the two pulses
// ACK2  | second pulse low, vector on the bus
module isr_ctl
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
`ifdef ISR_AEOI_EN
  input  logic       aeoi,
`endif
  input  logic       intr_in,
  input  logic [2:0] code_in,
  input  logic       inta_n,
  input  logic       ocw_wr,
  input  logic [2:0] ocw_cmd,
  input  logic [2:0] ocw_level,
  input  logic [4:0] vec_base,
  output logic [7:0] isr,
  output logic [2:0] sp,
  output logic       int_out,
  output logic [7:0] vec_out,
  output logic       vec_oe,
  output logic [7:0] irr_clr
);

  isr_state_e state_q, state_d;
  logic       inta_q;
  logic [7:0] isr_q, isr_d;
  logic [2:0] sp_q, sp_d;
  logic [2:0] lvl_q, lvl_d;
  logic       int_out_q, int_out_d;
  logic [7:0] vec_out_q, vec_out_d;
  logic       vec_oe_q, vec_oe_d;
  logic [7:0] irr_clr_q, irr_clr_d;

  logic       inta_fall, inta_rise;
  logic [7:0] isr_set, ocw_clr, aeoi_clr;
  logic       hp_hit;
  logic [2:0] hp_idx;

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // H is always searched in the pre-update ISR.
  isr_prio_find u_prio (
    .bits (isr_q),
    .sp   (sp_q),
    .hit  (hp_hit),
    .idx  (hp_idx)
  );

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    vec_out_d = vec_out_q;
    vec_oe_d  = vec_oe_q;
    irr_clr_d = '0;
    isr_set   = '0;
    aeoi_clr  = '0;

    case (state_q)
      ST_IDLE: begin
        if (inta_fall) begin
          state_d = ST_ACK1;
          if (intr_in) begin
            lvl_d     = code_in;
            isr_set   = lvl_onehot(code_in);
            irr_clr_d = lvl_onehot(code_in);
          end else begin
            lvl_d = LVL_SPURIOUS;
          end
        end
      end
      ST_ACK1: begin
        if (inta_rise) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (inta_fall) begin
          state_d   = ST_ACK2;
          vec_out_d = {vec_base, lvl_q};
          vec_oe_d  = 1'b1;
        end
      end
      ST_ACK2: begin
        if (inta_rise) begin
          state_d  = ST_IDLE;
          vec_oe_d = 1'b0;
`ifdef ISR_AEOI_EN
          if (aeoi) aeoi_clr = lvl_onehot(lvl_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ocw_clr = '0;
    sp_d    = sp_q;
    if (ocw_wr) begin
      case (ocw_cmd)
        OCW_NS_EOI: begin
          if (hp_hit) ocw_clr = lvl_onehot(hp_idx);
        end
        OCW_SP_EOI: ocw_clr = lvl_onehot(ocw_level);
        OCW_ROT_NS: begin
          if (hp_hit) begin
            ocw_clr = lvl_onehot(hp_idx);
            sp_d    = hp_idx;
          end
        end
        OCW_ROT_SP: begin
          ocw_clr = lvl_onehot(ocw_level);
          sp_d    = ocw_level;
        end
        OCW_SET_PRI: sp_d = ocw_level;
        default: ;
      endcase
    end
  end

  // A set and a clear on the same bit in one cycle: the set wins.
  assign isr_d     = (isr_q & ~(ocw_clr | aeoi_clr)) | isr_set;
  assign int_out_d = (state_d == ST_IDLE) ? intr_in : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      inta_q    <= 1'b1;
      isr_q     <= '0;
      sp_q      <= 3'd7;
      lvl_q     <= '0;
      int_out_q <= 1'b0;
      vec_out_q <= '0;
      vec_oe_q  <= 1'b0;
      irr_clr_q <= '0;
    end else begin
      state_q   <= state_d;
      inta_q    <= inta_n;
      isr_q     <= isr_d;
      sp_q      <= sp_d;
      lvl_q     <= lvl_d;
      int_out_q <= int_out_d;
      vec_out_q <= vec_out_d;
      vec_oe_q  <= vec_oe_d;
      irr_clr_q <= irr_clr_d;
    end
  end

  assign isr     = isr_q;
  assign sp      = sp_q;
  assign int_out = int_out_q;
  assign vec_out = vec_out_q;
  assign vec_oe  = vec_oe_q;
  assign irr_clr = irr_clr_q;

endmodule

// File: tb/tb_isr_ctl.sv
module tb_isr_ctl;

`ifdef ISR_AEOI_EN
  localparam bit AEOI_BUILD = 1'b1;
  logic       aeoi;
`else
  localparam bit AEOI_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       intr_in;
  logic [2:0] code_in;
  logic       inta_n;
  logic       ocw_wr;
  logic [2:0] ocw_cmd;
  logic [2:0] ocw_level;
  logic [4:0] vec_base;
  logic [7:0] isr;
  logic [2:0] sp;
  logic       int_out;
  logic [7:0] vec_out;
  logic       vec_oe;
  logic [7:0] irr_clr;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m_isr;
  int         m_sp;

  isr_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ISR_AEOI_EN
    .aeoi      (aeoi),
`endif
    .intr_in   (intr_in),
    .code_in   (code_in),
    .inta_n    (inta_n),
    .ocw_wr    (ocw_wr),
    .ocw_cmd   (ocw_cmd),
    .ocw_level (ocw_level),
    .vec_base  (vec_base),
    .isr       (isr),
    .sp        (sp),
    .int_out   (int_out),
    .vec_out   (vec_out),
    .vec_oe    (vec_oe),
    .irr_clr   (irr_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Reference OCW2 behaviour: priority rank r=1 is level sp+1, rank 8 is sp.
  task automatic model_ocw(input logic [2:0] cmd, input logic [2:0] lv, output logic [7:0] clr);
    int h;
    h   = -1;
    clr = '0;
    for (int r = 1; r <= 8; r++) begin
      int l;
      l = (m_sp + r) % 8;
      if (h < 0 && m_isr[l]) h = l;
    end
    case (cmd)
      3'b001: if (h >= 0) clr[h] = 1'b1;
      3'b011: clr[lv] = 1'b1;
      3'b101: if (h >= 0) begin clr[h] = 1'b1; m_sp = h; end
      3'b111: begin clr[lv] = 1'b1; m_sp = int'(lv); end
      3'b110: m_sp = int'(lv);
      default: ;
    endcase
  endtask

  task automatic do_ocw(input logic [2:0] cmd, input logic [2:0] lv);
    logic [7:0] clr;
    intr_in   = 1'($urandom_range(0, 1));
    ocw_wr    = 1'b1;
    ocw_cmd   = cmd;
    ocw_level = lv;
    model_ocw(cmd, lv, clr);
    m_isr = m_isr & ~clr;
    tick();
    ocw_wr = 1'b0;
    chk("ocw_isr", isr, m_isr);
    chk("ocw_sp", sp, m_sp[2:0]);
    chk("ocw_int_out", int_out, intr_in);
    chk("ocw_irr_clr", irr_clr, 8'h00);
  endtask

  // Full two-pulse acknowledge; optional OCW2 write in the first low cycle.
  task automatic do_ack(input logic intr, input logic [2:0] code, input int l1, input int g,
                        input int l2, input logic col, input logic [2:0] ccmd,
                        input logic [2:0] clvl, input logic ae);
    logic [7:0] set_m, clr;
    logic [2:0] lvl;
    lvl   = intr ? code : 3'd7;
    set_m = intr ? (8'h01 << code) : 8'h00;
    clr   = '0;
    if (col) model_ocw(ccmd, clvl, clr);
    m_isr = (m_isr & ~clr) | set_m;
    intr_in   = intr;
    code_in   = code;
    ocw_wr    = col;
    ocw_cmd   = ccmd;
    ocw_level = clvl;
`ifdef ISR_AEOI_EN
    aeoi = ae;
`endif
    inta_n = 1'b0;
    tick();
    ocw_wr = 1'b0;
    chk("ack1_irr_clr", irr_clr, set_m);
    chk("ack1_isr", isr, m_isr);
    chk("ack1_sp", sp, m_sp[2:0]);
    chk("ack1_int_out", int_out, 1'b0);
    for (int i = 1; i < l1; i++) begin
      tick();
      chk("ack1_irr_width", irr_clr, 8'h00);
    end
    inta_n = 1'b1;
    tick();
    chk("gap_irr_clr", irr_clr, 8'h00);
    chk("gap_int_out", int_out, 1'b0);
    chk("gap_vec_oe", vec_oe, 1'b0);
    for (int i = 1; i < g; i++) tick();
    inta_n = 1'b0;
    tick();
    chk("ack2_vec_oe", vec_oe, 1'b1);
    chk("ack2_vec_out", vec_out, {vec_base, lvl});
    chk("ack2_int_out", int_out, 1'b0);
    for (int i = 1; i < l2; i++) begin
      tick();
      chk("ack2_vec_hold", vec_oe, 1'b1);
    end
    inta_n = 1'b1;
    if (AEOI_BUILD && ae) m_isr[lvl] = 1'b0;
    tick();
    chk("end_vec_oe", vec_oe, 1'b0);
    chk("end_isr", isr, m_isr);
    chk("end_int_out", int_out, intr);
  endtask

  initial begin
    rst_n     = 1'b0;
    intr_in   = 1'b0;
    code_in   = 3'd0;
    inta_n    = 1'b1;
    ocw_wr    = 1'b0;
    ocw_cmd   = 3'd0;
    ocw_level = 3'd0;
    vec_base  = 5'h08;
`ifdef ISR_AEOI_EN
    aeoi = 1'b0;
`endif
    m_isr = 8'h00;
    m_sp  = 7;
    tick();
    tick();
    chk("rst_isr", isr, 8'h00);
    chk("rst_sp", sp, 3'd7);
    chk("rst_int_out", int_out, 1'b0);
    chk("rst_vec_out", vec_out, 8'h00);
    chk("rst_vec_oe", vec_oe, 1'b0);
    chk("rst_irr_clr", irr_clr, 8'h00);
    rst_n = 1'b1;

    // Basic acknowledge of level 3 with base 0x08: vector 0x43.
    intr_in = 1'b1;
    code_in = 3'd3;
    tick();
    chk("idle_int_out", int_out, 1'b1);
    do_ack(1'b1, 3'd3, 1, 1, 1, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("basic_isr", isr, 8'h08);

    // Spurious acknowledge.
    do_ack(1'b0, 3'd2, 2, 2, 2, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("spur_isr", isr, 8'h08);

    // EOI ordering and rotation.
    do_ocw(3'b011, 3'd3);
    do_ack(1'b1, 3'd0, 1, 1, 1, 1'b0, 3'd0, 3'd0, 1'b0);
    do_ack(1'b1, 3'd6, 1, 1, 1, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("pre_ns_isr", isr, 8'h41);
    do_ocw(3'b001, 3'd0);
    chk("ns_eoi_isr", isr, 8'h40);
    do_ocw(3'b101, 3'd0);
    chk("rot_ns_isr", isr, 8'h00);
    chk("rot_ns_sp", sp, 3'd6);
    do_ocw(3'b110, 3'd2);
    chk("set_pri_sp", sp, 3'd2);
    do_ack(1'b1, 3'd0, 1, 1, 1, 1'b0, 3'd0, 3'd0, 1'b0);
    do_ack(1'b1, 3'd3, 1, 1, 1, 1'b0, 3'd0, 3'd0, 1'b0);
    do_ocw(3'b001, 3'd0);
    chk("pri_order_isr", isr, 8'h01);
    do_ocw(3'b011, 3'd0);
    // Non-specific EOI on an empty ISR is a no-op.
    do_ocw(3'b101, 3'd0);
    chk("empty_rot_sp", sp, 3'd2);

    // Set and specific-EOI clear of level 5 in the same cycle.
    do_ack(1'b1, 3'd5, 1, 1, 1, 1'b1, 3'b011, 3'd5, 1'b0);
    chk("collide_isr5", isr[5], 1'b1);

    // AEOI: level 2 in service during the handshake, cleared after.
    do_ack(1'b1, 3'd2, 2, 1, 2, 1'b0, 3'd0, 3'd0, 1'b1);
    chk("aeoi_isr2", isr[2], AEOI_BUILD ? 1'b0 : 1'b1);

    // Reset while in GAP.
    intr_in = 1'b1;
    code_in = 3'd4;
    inta_n  = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    rst_n  = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    chk("gaprst_isr", isr, 8'h00);
    chk("gaprst_sp", sp, 3'd7);
    chk("gaprst_vec_oe", vec_oe, 1'b0);
    chk("gaprst_int_out", int_out, 1'b0);
    rst_n = 1'b1;
    m_isr = 8'h00;
    m_sp  = 7;
    tick();
    do_ack(1'b1, 3'd4, 1, 1, 1, 1'b0, 3'd0, 3'd0, 1'b0);

    // Randomized mix of acknowledges and OCW2 writes.
    for (int n = 0; n < 200; n++) begin
      vec_base = 5'($urandom);
      if ($urandom_range(0, 9) < 6)
        do_ack($urandom_range(0, 9) < 8, 3'($urandom), $urandom_range(1, 3),
               $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 4) == 0,
               3'($urandom), 3'($urandom), 1'($urandom));
      else
        do_ocw(3'($urandom), 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
